// File: rtl/timing_pkg.sv
// Shared time-base constants for counter consumers, plus the parameter
// legality check used by generic_counter at elaboration.
package timing_pkg;

  localparam int VGA_H_MAX   = 799;
  localparam int VGA_V_MAX   = 524;
  localparam int CLK_DIV_MAX = 3;

  // True when a counter of this width can represent every state 0..max.
  function automatic bit counter_fits(input int width, input int max);
    if (width < 1 || max < 0) return 1'b0;
    if (width >= 31) return 1'b1;
    return max < (1 << width);
  endfunction

endpackage

// File: rtl/generic_counter.sv
// Modulo counter 0..COUNTER_MAX with a one-cycle registered wrap pulse;
// chain stages by feeding TRIG_OUT into the next stage's ENABLE.
module generic_counter
  import timing_pkg::*;
#(
  parameter int COUNTER_WIDTH = 4,
  parameter int COUNTER_MAX   = 9
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ENABLE,
  output logic                     TRIG_OUT,
  output logic [COUNTER_WIDTH-1:0] COUNT
);

  if (!counter_fits(COUNTER_WIDTH, COUNTER_MAX)) begin : g_param_check
    $error("generic_counter: COUNTER_MAX must be < 2**COUNTER_WIDTH and COUNTER_WIDTH >= 1");
  end

  localparam logic [COUNTER_WIDTH-1:0] MAX_VAL = COUNTER_WIDTH'(COUNTER_MAX);

  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic                     trig_q, trig_d;
  logic                     at_max;

  // >= rather than == so an out-of-range value recovers to 0 on the next enabled edge.
  assign at_max = (count_q >= MAX_VAL);

  always_comb begin
    count_d = count_q;
    trig_d  = 1'b0;
    if (ENABLE) begin
      if (at_max) begin
        count_d = '0;
        trig_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) count_q <= '0;
    else        count_q <= count_d;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) trig_q <= 1'b0;
    else        trig_q <= trig_d;
  end

  assign COUNT    = count_q;
  assign TRIG_OUT = trig_q;

endmodule

// File: tb/tb_generic_counter.sv
// Bench for generic_counter: H(6b/44) cascaded into V(5b/31), plus a 4b/15
// stage and a MAX=0 stage, checked against an arithmetic modulo model.
module tb_generic_counter;

  logic       clk;
  logic       rst_n;
  logic       en_h, en_15, en_0;
  logic       h_trig, v_trig, t15, t0;
  logic [5:0] h_cnt;
  logic [4:0] v_cnt;
  logic [3:0] c15;
  logic [0:0] c0;

  generic_counter #(.COUNTER_WIDTH(6), .COUNTER_MAX(44)) u_h (
    .CLK(clk), .RESET(rst_n), .ENABLE(en_h), .TRIG_OUT(h_trig), .COUNT(h_cnt));
  generic_counter #(.COUNTER_WIDTH(5), .COUNTER_MAX(31)) u_v (
    .CLK(clk), .RESET(rst_n), .ENABLE(h_trig), .TRIG_OUT(v_trig), .COUNT(v_cnt));
  generic_counter #(.COUNTER_WIDTH(4), .COUNTER_MAX(15)) u_15 (
    .CLK(clk), .RESET(rst_n), .ENABLE(en_15), .TRIG_OUT(t15), .COUNT(c15));
  generic_counter #(.COUNTER_WIDTH(1), .COUNTER_MAX(0)) u_0 (
    .CLK(clk), .RESET(rst_n), .ENABLE(en_0), .TRIG_OUT(t0), .COUNT(c0));

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // reference model: each stage is an integer modulo (MAX+1) plus a pulse flag
  int mh, mv, m15, m0;
  bit th, tv, tm15, tm0;
  logic [5:0] exp_q[$];

  task automatic model_reset();
    mh = 0; mv = 0; m15 = 0; m0 = 0;
    th = 0; tv = 0; tm15 = 0; tm0 = 0;
  endtask

  task automatic model_edge();
    bit v_en;
    if (!rst_n) begin
      model_reset();
    end else begin
      v_en = th;
      th   = en_h  && (mh  == 44);
      tv   = v_en  && (mv  == 31);
      tm15 = en_15 && (m15 == 15);
      tm0  = en_0  && (m0  == 0);
      if (en_h)  mh  = (mh  + 1) % 45;
      if (v_en)  mv  = (mv  + 1) % 32;
      if (en_15) m15 = (m15 + 1) % 16;
      if (en_0)  m0  = (m0  + 1) % 1;
    end
    exp_q.push_back(6'(mh));
  endtask

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_all();
    logic [5:0] e;
    e = exp_q.pop_front();
    check("h_count", int'(h_cnt), int'(e));
    check("h_trig",  int'(h_trig), int'(th));
    check("v_count", int'(v_cnt), mv);
    check("v_trig",  int'(v_trig), int'(tv));
    check("c15_count", int'(c15), m15);
    check("c15_trig",  int'(t15), int'(tm15));
    check("c0_count",  int'(c0), m0);
    check("c0_trig",   int'(t0), int'(tm0));
  endtask

  // driver: one clock edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       en15;
    logic       en0;
    logic [3:0] exp15;
    logic       expt15;
    logic       expt0;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int   last_pulse;
    int   found;
    int   cyc;
    logic prev_trig;

    vecs[0] = '{1'b1, 1'b1, 4'd15, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 4'd0,  1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 4'd1,  1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 4'd1,  1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 4'd2,  1'b0, 1'b0};

    // reset held with ENABLE high, then an async pulse between edges
    rst_n = 1'b0; en_h = 1'b1; en_15 = 1'b1; en_0 = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("pre_async_h_count", int'(h_cnt), 5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_h_count", int'(h_cnt), 0);
    check("async_h_trig", int'(h_trig), 0);
    check("async_c15", int'(c15), 0);
    rst_n = 1'b1;

    // table vectors on the 4b/MAX15 and MAX0 stages
    do_reset();
    en_h = 1'b0; en_15 = 1'b1; en_0 = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check("c15_preroll", int'(c15), 14);
    for (int i = 0; i < 6; i++) begin
      en_15 = vecs[i].en15;
      en_0  = vecs[i].en0;
      step();
      check($sformatf("vec%0d_c15", i), int'(c15), int'(vecs[i].exp15));
      check($sformatf("vec%0d_t15", i), int'(t15), int'(vecs[i].expt15));
      check($sformatf("vec%0d_t0", i), int'(t0), int'(vecs[i].expt0));
    end

    // free run + cascade: H period 45, V wraps on the 32nd H pulse
    do_reset();
    en_h = 1'b1; en_15 = 1'b1; en_0 = 1'b1;
    last_pulse = 0;
    found = 0;
    for (int i = 1; i <= 45 * 32 + 5; i++) begin
      step();
      if (h_trig) begin
        check("h_trig_count_zero", int'(h_cnt), 0);
        check("h_period", i - last_pulse, 45);
        last_pulse = i;
      end
      if (v_trig && found == 0) begin
        found = i;
        check("v_wrap_count", int'(v_cnt), 0);
      end
    end
    check("v_wrap_cycle", found, 45 * 32 + 1);

    // enable toggling: 44 enabled edges in 88 cycles, no stretched pulse
    do_reset();
    prev_trig = 1'b0;
    for (int i = 0; i < 88; i++) begin
      en_h = (i % 2 == 0);
      step();
      check("trig_single_cycle", int'(prev_trig && h_trig), 0);
      prev_trig = h_trig;
    end
    check("toggle_h_count", int'(h_cnt), 44);

    // randomized enables
    for (int i = 0; i < 400; i++) begin
      en_h  = 1'($urandom_range(0, 1));
      en_15 = 1'($urandom_range(0, 1));
      en_0  = 1'($urandom_range(0, 1));
      step();
    end

    // reset during the wrap pulse, then restart from 0
    do_reset();
    en_h = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (h_trig) found = 1;
    end
    check("pulse_seen", found, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midpulse_trig", int'(h_trig), 0);
    check("midpulse_count", int'(h_cnt), 0);
    rst_n = 1'b1;
    cyc = 0;
    found = 0;
    for (int i = 1; i <= 100 && !found; i++) begin
      step();
      if (h_trig) begin
        found = 1;
        cyc = i;
      end
    end
    check("restart_pulse_delay", cyc, 45);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
